// File: rtl/synfull_inj_sched.sv
// synfull_inj_sched: request queue and issue scheduler between a SynFull
// style traffic generator and a packet injector.
//
// Requests arrive without backpressure. While issue is enabled (RUN or
// DRAIN) the queue head goes to the injector whenever it is ready. With an
// empty queue, a request can bypass straight to the injector in the same
// cycle. FIFO order is kept across both paths. A request that meets a full
// queue with no pop that cycle is lost, and sets the sticky overflow flag.
// A request that arrives after DONE is also lost and also sets that flag.
//
// Optional feature macro: SYNFULL_INJ_STAT_EN. It adds statistics counters
// (queued, sent, dropped, stall cycles, peak occupancy).
//
// Handshake: the injector side is valid/ready. inj_wr_o asserts only when
// inj_ready_i is 1, and the packet counts as transferred in that cycle.
// The request side has no ready signal. Every req_valid_i cycle gives one
// of three results: it is bypassed, it is pushed, or it is dropped.

module synfull_inj_sched #(
  parameter int DEPTH = 16,
  parameter int IDw   = 32,
  parameter int SIZEw = 8,
  parameter int DSTw  = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_i,
  input  logic                         end_i,
  input  logic                         req_valid_i,
  input  logic [IDw-1:0]               req_id_i,
  input  logic [SIZEw-1:0]             req_size_i,
  input  logic [DSTw-1:0]              req_dest_i,
  input  logic                         inj_ready_i,
  output logic                         inj_wr_o,
  output logic [IDw-1:0]               inj_id_o,
  output logic [SIZEw-1:0]             inj_size_o,
  output logic [DSTw-1:0]              inj_dest_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
  output logic                         overflow_o,
  output logic                         drained_o,
  output logic [1:0]                   state_o
`ifdef SYNFULL_INJ_STAT_EN
  ,
  output logic [63:0]                  queued_cnt_o,
  output logic [63:0]                  sent_cnt_o,
  output logic [63:0]                  drop_cnt_o,
  output logic [63:0]                  stall_cnt_o,
  output logic [$clog2(DEPTH+1)-1:0]   max_occ_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = IDw + SIZEw + DSTw;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state;
  logic [PW-1:0]  mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [CW-1:0]  occ;
  logic [CW-1:0]  occ_nxt;

  logic           empty;
  logic           full;
  logic           issue_en;
  logic           pop;
  logic           bypass;
  logic           push_try;
  logic           push;
  logic           drop;
  logic [PW-1:0]  head;
  logic [PW-1:0]  req_pkt;
  logic [PW-1:0]  out_pkt;

  assign req_pkt  = {req_id_i, req_size_i, req_dest_i};
  assign head     = mem[rd_ptr];
  assign empty    = (occ == '0);
  assign full     = (occ == CW'(DEPTH));
  assign issue_en = (state == S_RUN) || (state == S_DRAIN);

  // The queue head always has priority over a new request, so FIFO order is kept.
  assign pop      = issue_en && !empty && inj_ready_i;
  assign bypass   = issue_en && empty && req_valid_i && inj_ready_i;
  // A pop in the same cycle frees a slot, so a full queue can still accept a push.
  assign push_try = req_valid_i && (state != S_DONE) && !bypass;
  assign push     = push_try && (!full || pop);
  assign drop     = (push_try && full && !pop) || (req_valid_i && (state == S_DONE));

  // Injector outputs: the queue head when the queue has data, otherwise the bypassed request.
  always_comb begin
    out_pkt  = req_pkt;
    inj_wr_o = pop || bypass;
    if (pop) out_pkt = head;
  end

  assign inj_id_o    = out_pkt[PW-1 -: IDw];
  assign inj_size_o  = out_pkt[DSTw +: SIZEw];
  assign inj_dest_o  = out_pkt[DSTw-1:0];
  assign occupancy_o = occ;
  assign state_o     = state;

  // Next occupancy: a simultaneous push and pop cancel out.
  always_comb begin
    occ_nxt = occ;
    case ({push, pop})
      2'b10:   occ_nxt = occ + CW'(1);
      2'b01:   occ_nxt = occ - CW'(1);
      default: occ_nxt = occ;
    endcase
  end

  // Queue storage. It has no reset, because the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_pkt;
  end

  // Pointers and occupancy. The pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      occ <= occ_nxt;
    end
  end

  // Sticky flag for a lost request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     overflow_o <= 1'b0;
    else if (drop) overflow_o <= 1'b1;
  end

  // Control FSM. drained_o is registered next to the state and is high exactly while in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      drained_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (end_i)        state <= S_DRAIN;
          else if (start_i) state <= S_RUN;
        end
        S_RUN: begin
          if (end_i) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (empty && !req_valid_i) begin
            state     <= S_DONE;
            drained_o <= 1'b1;
          end
        end
        default: begin
          state     <= S_DONE;
          drained_o <= 1'b1;
        end
      endcase
    end
  end

`ifdef SYNFULL_INJ_STAT_EN
  // Statistics counters. A request counts as queued if it was pushed or bypassed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      queued_cnt_o <= '0;
      sent_cnt_o   <= '0;
      drop_cnt_o   <= '0;
      stall_cnt_o  <= '0;
      max_occ_o    <= '0;
    end else begin
      if (push || bypass)                   queued_cnt_o <= queued_cnt_o + 64'd1;
      if (inj_wr_o)                         sent_cnt_o   <= sent_cnt_o + 64'd1;
      if (drop)                             drop_cnt_o   <= drop_cnt_o + 64'd1;
      if (issue_en && !empty && !inj_ready_i) stall_cnt_o <= stall_cnt_o + 64'd1;
      if (occ_nxt > max_occ_o)              max_occ_o    <= occ_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_synfull_inj_sched.sv
// Testbench for synfull_inj_sched. The reference model is a packet queue
// plus a phase variable that follows the scheduler rules. The directed
// scenarios check against fixed expected values. A randomized phase checks
// every cycle against the model.

module tb_synfull_inj_sched;

  localparam int DEPTH = 16;
  localparam int PW    = 46;
  localparam int CW    = 5;

  // Clock and reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Driven inputs
  logic        start_in, end_in, req_valid, inj_ready;
  logic [31:0] req_id;
  logic [7:0]  req_size;
  logic [5:0]  req_dest;

  // DUT outputs
  logic          inj_wr;
  logic [31:0]   inj_id;
  logic [7:0]    inj_size;
  logic [5:0]    inj_dest;
  logic [CW-1:0] occupancy;
  logic          overflow, drained;
  logic [1:0]    state;
`ifdef SYNFULL_INJ_STAT_EN
  logic [63:0]   queued_cnt, sent_cnt, drop_cnt, stall_cnt;
  logic [CW-1:0] max_occ;
`endif

  synfull_inj_sched dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_in),
    .end_i       (end_in),
    .req_valid_i (req_valid),
    .req_id_i    (req_id),
    .req_size_i  (req_size),
    .req_dest_i  (req_dest),
    .inj_ready_i (inj_ready),
    .inj_wr_o    (inj_wr),
    .inj_id_o    (inj_id),
    .inj_size_o  (inj_size),
    .inj_dest_o  (inj_dest),
    .occupancy_o (occupancy),
    .overflow_o  (overflow),
    .drained_o   (drained),
    .state_o     (state)
`ifdef SYNFULL_INJ_STAT_EN
    ,
    .queued_cnt_o(queued_cnt),
    .sent_cnt_o  (sent_cnt),
    .drop_cnt_o  (drop_cnt),
    .stall_cnt_o (stall_cnt),
    .max_occ_o   (max_occ)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: packets waiting in order, the phase, and the sticky loss flag
  logic [PW-1:0] exp_q[$];
  int            m_phase;   // 0 idle, 1 run, 2 drain, 3 done
  bit            m_lost;

  // Per-cycle expected and observed values
  logic          exp_wr, obs_wr;
  logic [PW-1:0] exp_pkt, obs_pkt;
  logic [CW-1:0] exp_occ, obs_occ;
  logic          exp_ovf, obs_ovf, exp_drained, obs_drained;
  logic [1:0]    exp_state, obs_state;

  task automatic clear_inputs();
    start_in = 0; end_in = 0; req_valid = 0; inj_ready = 0;
    req_id = '0; req_size = '0; req_dest = '0;
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_phase = 0;
    m_lost  = 0;
  endtask

  task automatic set_req(input logic [31:0] id);
    req_valid = 1;
    req_id    = id;
    req_size  = 8'($urandom_range(1, 255));
    req_dest  = 6'($urandom_range(0, 63));
  endtask

  // One clock cycle: sample the DUT mid-cycle, form the model's expectation, then advance the model
  task automatic tick();
    logic [PW-1:0] cur;
    bit issue, took_head, went_direct;
    int n;
    @(negedge clk);
    cur   = {req_id, req_size, req_dest};
    issue = (m_phase == 1) || (m_phase == 2);
    n     = exp_q.size();
    if (issue && n > 0) begin
      exp_wr = inj_ready; exp_pkt = exp_q[0];
    end else if (issue && req_valid && inj_ready) begin
      exp_wr = 1'b1; exp_pkt = cur;
    end else begin
      exp_wr = 1'b0; exp_pkt = '0;
    end
    exp_occ     = CW'(n);
    exp_ovf     = m_lost;
    exp_state   = 2'(m_phase);
    exp_drained = (m_phase == 3);
    obs_wr      = inj_wr;
    obs_pkt     = {inj_id, inj_size, inj_dest};
    obs_occ     = occupancy;
    obs_ovf     = overflow;
    obs_state   = state;
    obs_drained = drained;
    took_head   = issue && n > 0 && inj_ready;
    went_direct = issue && n == 0 && req_valid && inj_ready;
    if (took_head) void'(exp_q.pop_front());
    if (req_valid) begin
      if (m_phase == 3) m_lost = 1;
      else if (!went_direct) begin
        if (n == DEPTH && !took_head) m_lost = 1;
        else exp_q.push_back(cur);
      end
    end
    case (m_phase)
      0: if (end_in) m_phase = 2; else if (start_in) m_phase = 1;
      1: if (end_in) m_phase = 2;
      2: if (n == 0 && !req_valid) m_phase = 3;
      default: m_phase = 3;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    reset = 1;
    clear_inputs();
    model_clear();
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    clear_inputs();
    model_clear();
    #2;
    checks++;
    if ({state, occupancy, overflow, drained, inj_wr} !== {2'd0, 5'd0, 1'b0, 1'b0, 1'b0})
      begin errors++; $display("FAIL reset_values: got st=%0d occ=%0d ovf=%0b drn=%0b wr=%0b expected all 0",
        state, occupancy, overflow, drained, inj_wr); end
    req_valid = 1; inj_ready = 1;
    #1;
    checks++;
    if (inj_wr !== 1'b0) begin errors++; $display("FAIL reset_no_wr: got %0b expected 0", inj_wr); end
    clear_inputs();
    #4;
    reset = 0;
    @(posedge clk);
    #1;
    set_req(32'd9); inj_ready = 1;
    tick();
    clear_inputs();
    checks++;
    if (obs_wr !== 1'b0 || obs_state !== 2'd0)
      begin errors++; $display("FAIL idle_no_issue: got wr=%0b st=%0d expected wr=0 st=0", obs_wr, obs_state); end
  endtask

  task automatic test_bypass();
    apply_reset();
    start_in = 1;
    tick();
    start_in = 0;
    set_req(32'd5); req_size = 8'd4; req_dest = 6'd3; inj_ready = 1;
    tick();
    req_valid = 0;
    checks++;
    if ({obs_wr, obs_pkt, obs_occ, obs_state} !== {1'b1, 32'd5, 8'd4, 6'd3, 5'd0, 2'd1})
      begin errors++; $display("FAIL bypass: got wr=%0b id=%0d size=%0d dest=%0d occ=%0d expected 1,5,4,3,0",
        obs_wr, obs_pkt[45:14], obs_pkt[13:6], obs_pkt[5:0], obs_occ); end
    tick();
    checks++;
    if (obs_wr !== 1'b0 || obs_occ !== 5'd0)
      begin errors++; $display("FAIL bypass_no_store: got wr=%0b occ=%0d expected 0,0", obs_wr, obs_occ); end
  endtask

  task automatic test_idle_queue();
    apply_reset();
    inj_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      set_req(32'(i));
      tick();
      checks++;
      if (obs_wr !== 1'b0) begin errors++; $display("FAIL idle_queue_wr: got %0b expected 0", obs_wr); end
    end
    req_valid = 0;
    start_in = 1;
    tick();
    start_in = 0;
    checks++;
    if (obs_wr !== 1'b0 || obs_occ !== 5'd3)
      begin errors++; $display("FAIL idle_queue_occ: got wr=%0b occ=%0d expected 0,3", obs_wr, obs_occ); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (obs_wr !== 1'b1 || obs_pkt[45:14] !== 32'(i) || obs_occ !== 5'(4 - i))
        begin errors++; $display("FAIL idle_queue_issue: got wr=%0b id=%0d occ=%0d expected 1,%0d,%0d",
          obs_wr, obs_pkt[45:14], obs_occ, i, 4 - i); end
    end
    tick();
    checks++;
    if (obs_occ !== 5'd0) begin errors++; $display("FAIL idle_queue_empty: got %0d expected 0", obs_occ); end
  endtask

  task automatic test_overflow();
    apply_reset();
    start_in = 1;
    tick();
    start_in = 0;
    for (int i = 1; i <= 17; i++) begin
      set_req(32'(i));
      tick();
    end
    req_valid = 0;
    tick();
    checks++;
    if (obs_occ !== 5'd16 || obs_ovf !== 1'b1)
      begin errors++; $display("FAIL overflow_full: got occ=%0d ovf=%0b expected 16,1", obs_occ, obs_ovf); end
`ifdef SYNFULL_INJ_STAT_EN
    checks++;
    if (drop_cnt !== 64'd1) begin errors++; $display("FAIL overflow_drop_cnt: got %0d expected 1", drop_cnt); end
`endif
    inj_ready = 1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++;
      if (obs_wr !== 1'b1 || obs_pkt[45:14] !== 32'(i))
        begin errors++; $display("FAIL overflow_order: got wr=%0b id=%0d expected 1,%0d", obs_wr, obs_pkt[45:14], i); end
    end
    tick();
    checks++;
    if (obs_occ !== 5'd0) begin errors++; $display("FAIL overflow_drained: got %0d expected 0", obs_occ); end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    start_in = 1;
    tick();
    start_in = 0;
    for (int i = 1; i <= 16; i++) begin
      set_req(32'(i));
      tick();
    end
    set_req(32'd100); inj_ready = 1;
    tick();
    req_valid = 0; inj_ready = 0;
    checks++;
    if (obs_wr !== 1'b1 || obs_pkt[45:14] !== 32'd1)
      begin errors++; $display("FAIL full_pop: got wr=%0b id=%0d expected 1,1", obs_wr, obs_pkt[45:14]); end
    tick();
    checks++;
    if (obs_occ !== 5'd16 || obs_ovf !== 1'b0)
      begin errors++; $display("FAIL full_push: got occ=%0d ovf=%0b expected 16,0", obs_occ, obs_ovf); end
    inj_ready = 1;
    for (int i = 2; i <= 17; i++) begin
      tick();
      checks++;
      if (obs_pkt[45:14] !== ((i == 17) ? 32'd100 : 32'(i)) || obs_wr !== 1'b1)
        begin errors++; $display("FAIL full_order: got wr=%0b id=%0d at step %0d", obs_wr, obs_pkt[45:14], i); end
    end
  endtask

  task automatic test_drain();
    apply_reset();
    start_in = 1;
    tick();
    start_in = 0;
    set_req(32'd7); tick();
    set_req(32'd8); tick();
    req_valid = 0;
    end_in = 1; inj_ready = 1;
    tick();
    end_in = 0;
    checks++;
    if (obs_wr !== 1'b1 || obs_pkt[45:14] !== 32'd7 || obs_state !== 2'd1)
      begin errors++; $display("FAIL drain_first: got wr=%0b id=%0d st=%0d expected 1,7,1", obs_wr, obs_pkt[45:14], obs_state); end
    tick();
    checks++;
    if (obs_wr !== 1'b1 || obs_pkt[45:14] !== 32'd8 || obs_state !== 2'd2)
      begin errors++; $display("FAIL drain_second: got wr=%0b id=%0d st=%0d expected 1,8,2", obs_wr, obs_pkt[45:14], obs_state); end
    tick();
    checks++;
    if (obs_state !== 2'd2 || obs_occ !== 5'd0 || obs_drained !== 1'b0)
      begin errors++; $display("FAIL drain_empty: got st=%0d occ=%0d drn=%0b expected 2,0,0", obs_state, obs_occ, obs_drained); end
    tick();
    checks++;
    if (obs_state !== 2'd3 || obs_drained !== 1'b1)
      begin errors++; $display("FAIL drain_done: got st=%0d drn=%0b expected 3,1", obs_state, obs_drained); end
    set_req(32'd9);
    tick();
    req_valid = 0;
    checks++;
    if (obs_wr !== 1'b0) begin errors++; $display("FAIL done_no_wr: got %0b expected 0", obs_wr); end
    tick();
    checks++;
    if (obs_ovf !== 1'b1 || obs_occ !== 5'd0)
      begin errors++; $display("FAIL done_ovf: got ovf=%0b occ=%0d expected 1,0", obs_ovf, obs_occ); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    start_in = 1;
    tick();
    start_in = 0;
    for (int i = 1; i <= 5; i++) begin
      set_req(32'(i));
      tick();
    end
    req_valid = 0;
    checks++;
    if (occupancy !== 5'd5) begin errors++; $display("FAIL mid_fill: got %0d expected 5", occupancy); end
    #2;
    reset = 1;
    inj_ready = 1;
    model_clear();
    #1;
    checks++;
    if (occupancy !== 5'd0 || state !== 2'd0 || inj_wr !== 1'b0)
      begin errors++; $display("FAIL mid_async: got occ=%0d st=%0d wr=%0b expected 0,0,0", occupancy, state, inj_wr); end
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs_wr !== 1'b0 || obs_occ !== 5'd0)
        begin errors++; $display("FAIL mid_after: got wr=%0b occ=%0d expected 0,0", obs_wr, obs_occ); end
    end
    start_in = 1;
    tick();
    start_in = 0;
    tick();
    checks++;
    if (obs_wr !== 1'b0 || obs_state !== 2'd1)
      begin errors++; $display("FAIL mid_restart: got wr=%0b st=%0d expected 0,1", obs_wr, obs_state); end
  endtask

  task automatic test_random();
    int pct;
    for (int r = 0; r < 4; r++) begin
      apply_reset();
      case (r)
        0: pct = 85;
        1: pct = 40;
        2: pct = 10;
        default: pct = 60;
      endcase
      for (int c = 0; c < 200; c++) begin
        start_in  = (m_phase == 0) && ($urandom_range(0, 9) == 0);
        end_in    = (c > 120) && ($urandom_range(0, 39) == 0);
        req_valid = ($urandom_range(0, 99) < 60);
        req_id    = $urandom;
        req_size  = 8'($urandom);
        req_dest  = 6'($urandom);
        inj_ready = ($urandom_range(0, 99) < pct);
        tick();
        checks++;
        if ({obs_wr, obs_occ, obs_ovf, obs_state, obs_drained} !== {exp_wr, exp_occ, exp_ovf, exp_state, exp_drained})
          begin errors++; $display("FAIL random_ctrl r%0d c%0d: got wr=%0b occ=%0d ovf=%0b st=%0d drn=%0b expected %0b,%0d,%0b,%0d,%0b",
            r, c, obs_wr, obs_occ, obs_ovf, obs_state, obs_drained, exp_wr, exp_occ, exp_ovf, exp_state, exp_drained); end
        if (exp_wr) begin
          checks++;
          if (obs_pkt !== exp_pkt)
            begin errors++; $display("FAIL random_pkt r%0d c%0d: got %0h expected %0h", r, c, obs_pkt, exp_pkt); end
        end
      end
      clear_inputs();
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_idle_queue();
    test_overflow();
    test_full_push_pop();
    test_drain();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/synfull_inj_sched.md
SYNFULL_INJ_SCHED -- requirements
Module: synfull_inj_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning request queue entries (power of 2, >=2).
REQ-002 SHALL have parameter IDw, default 32, meaning packet id width.
REQ-003 SHALL have parameter SIZEw, default 8, meaning packet size (flits) width.
REQ-004 SHALL have parameter DSTw, default 6, meaning destination endpoint id width.
REQ-005 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high.
REQ-007 SHALL have port start_i  in  1  begin injection (one-cycle pulse).
REQ-008 SHALL have port end_i  in  1  traffic generator finished; level or pulse.
REQ-009 SHALL have port req_valid_i  in  1  new packet request; no backpressure possible.
REQ-010 SHALL have ports req_id_i  in  IDw; req_size_i  in  SIZEw; req_dest_i  in  DSTw  request fields.
REQ-011 SHALL have port inj_ready_i  in  1  packet injector can accept a packet this cycle.
REQ-012 SHALL have ports inj_wr_o  out  1; inj_id_o  out  IDw; inj_size_o  out  SIZEw; inj_dest_o  out  DSTw  packet issued to injector.
REQ-013 SHALL have port occupancy_o  out  clog2(DEPTH+1)  queued entries.
REQ-014 SHALL have port overflow_o  out  1  sticky: a request was lost.
REQ-015 SHALL have port drained_o  out  1  all requests issued after end.
REQ-016 SHALL have port state_o  out  2  FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3).

Function
REQ-017 FSM SHALL be: IDLE -> RUN on start_i; RUN -> DRAIN on end_i; DRAIN -> DONE when queue empty and req_valid_i=0; DONE terminal until reset; end_i in IDLE SHALL go directly to DRAIN.
REQ-018 Issue enable SHALL be state in {RUN, DRAIN}; in IDLE requests queue but inj_wr_o=0.
REQ-019 Queue non-empty and issue enabled: inj_wr_o=inj_ready_i, fields from head; head popped same edge.
REQ-020 Queue empty, issue enabled, req_valid_i=1, inj_ready_i=1: bypass, inj_wr_o=1 combinationally with req fields, nothing written.
REQ-021 Any other req_valid_i=1 outside DONE SHALL push to tail; strict FIFO order across bypass and queue.
REQ-022 inj_wr_o SHALL never assert when inj_ready_i=0; fields SHALL be don't-care when inj_wr_o=0.
REQ-023 Full queue with push and pop same cycle: both performed, occupancy unchanged.
REQ-024 Full queue with push and no pop: request dropped, overflow_o set next edge.
REQ-025 req_valid_i in DONE: request ignored, overflow_o set.
REQ-026 Pointers SHALL wrap modulo DEPTH; occupancy_o counts 0..DEPTH exactly.
REQ-027 drained_o SHALL equal (state==DONE), registered.

Reset
REQ-028 Reset SHALL asynchronously force state IDLE, pointers 0, occupancy_o=0, overflow_o=0, drained_o=0, inj_wr_o=0 (queue RAM contents not reset).
REQ-029 Reset mid-operation SHALL discard all queued requests; no inj_wr_o until next start_i.

Configuration
REQ-030 With SYNFULL_INJ_STAT_EN defined: outputs queued_cnt_o, sent_cnt_o, drop_cnt_o, stall_cnt_o (64 bits each) and max_occ_o SHALL exist, counting accepted requests, inj_wr_o pulses, dropped requests, cycles with issue enabled, queue non-empty and inj_ready_i=0, and peak occupancy; reset to 0.
REQ-031 Without SYNFULL_INJ_STAT_EN: those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-032 start, inj_ready=1, req id=5 size=4 dest=3 with empty queue -> inj_wr=1 same cycle, id=5, occupancy stays 0.
REQ-033 IDLE, 3 requests ids 1,2,3, then start with inj_ready=1 -> inj_wr on 3 consecutive cycles, ids 1,2,3, occupancy 3->0.
REQ-034 RUN, inj_ready=0, DEPTH=16, 17 requests -> occupancy 16, overflow=1, drop_cnt=1; raise inj_ready -> ids 1..16 in order.
REQ-035 Full queue, inj_ready=1 and req_valid same cycle -> pop id head, push accepted, occupancy 16, overflow=0.
REQ-036 RUN with 2 queued, end_i pulse, inj_ready=1 -> DRAIN, 2 issues, DONE one cycle after empty, drained=1; later req_valid -> overflow=1, no inj_wr.
REQ-037 Reset asserted with 5 queued mid-RUN -> occupancy 0, state IDLE immediately (asynchronous), no inj_wr after release until start_i.
